// File: rtl/decode_stage_buffered.sv
// RV32I decode stage between ifetch and rfetch with a BUF_DEPTH-entry decoded-instruction queue.
// Optional macro RVGA_DECODE_ILLEGAL_EN enables illegal-instruction flagging in cword[10].
module decode_stage_buffered #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CWORD_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [31:0]        in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [CWORD_W-1:0] out_cword
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_stage_buffered: XLEN must be 32");
  end
  if (BUF_DEPTH < 1 || BUF_DEPTH > 4) begin : g_depth_chk
    $error("decode_stage_buffered: BUF_DEPTH must be 1..4");
  end
  if (CWORD_W < 16) begin : g_cword_chk
    $error("decode_stage_buffered: CWORD_W must be at least 16");
  end

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, dec_imm;
  logic        rd_w_v, pc_w_v, dc_r_v, dc_w_v, imm_v, alt_art;
  logic        rs1_pc_sel, imm_pt_v, jump_v, branch_v, illegal, f3_v;
  logic [15:0]        dec_cword;
  logic [CWORD_W-1:0] dec_cword_ext;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    rd_w_v     = 1'b0;
    pc_w_v     = 1'b0;
    dc_r_v     = 1'b0;
    dc_w_v     = 1'b0;
    imm_v      = 1'b0;
    alt_art    = 1'b0;
    rs1_pc_sel = 1'b0;
    imm_pt_v   = 1'b0;
    jump_v     = 1'b0;
    branch_v   = 1'b0;
    illegal    = 1'b0;
    f3_v       = 1'b0;
    dec_imm    = '0;
    case (opc)
      OPC_LUI: begin
        rd_w_v = 1'b1; imm_v = 1'b1; imm_pt_v = 1'b1; dec_imm = imm_u;
      end
      OPC_AUIPC: begin
        rd_w_v = 1'b1; imm_v = 1'b1; rs1_pc_sel = 1'b1; dec_imm = imm_u;
      end
      OPC_OP: begin
        rd_w_v  = 1'b1; f3_v = 1'b1;
        alt_art = in_instr[30] && (f3 == 3'b000 || f3 == 3'b101);
      end
      OPC_OP_IMM: begin
        rd_w_v  = 1'b1; imm_v = 1'b1; f3_v = 1'b1;
        alt_art = in_instr[30] && (f3 == 3'b101);
        // shifts carry a zero-extended shamt, everything else a sign-extended I-imm
        dec_imm = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_instr[24:20]} : imm_i;
      end
      OPC_LOAD: begin
        rd_w_v = 1'b1; imm_v = 1'b1; dc_r_v = 1'b1; f3_v = 1'b1; dec_imm = imm_i;
      end
      OPC_STORE: begin
        imm_v = 1'b1; dc_w_v = 1'b1; f3_v = 1'b1; dec_imm = imm_s;
      end
      OPC_BRANCH: begin
        branch_v = 1'b1; imm_v = 1'b1; f3_v = 1'b1; dec_imm = imm_b;
      end
      OPC_JAL: begin
        rd_w_v = 1'b1; pc_w_v = 1'b1; jump_v = 1'b1; imm_v = 1'b1; rs1_pc_sel = 1'b1;
        dec_imm = imm_j;
      end
      OPC_JALR: begin
        rd_w_v = 1'b1; pc_w_v = 1'b1; jump_v = 1'b1; imm_v = 1'b1; f3_v = 1'b1;
        dec_imm = imm_i;
      end
      default: illegal = 1'b1;
    endcase
    if (opc == OPC_OP &&
        !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
      illegal = 1'b1;
    if (in_instr[1:0] != 2'b11)
      illegal = 1'b1;
    if (in_instr[11:7] == 5'd0)
      rd_w_v = 1'b0;
`ifdef RVGA_DECODE_ILLEGAL_EN
    if (illegal) begin
      rd_w_v = 1'b0;
      pc_w_v = 1'b0;
      dc_r_v = 1'b0;
      dc_w_v = 1'b0;
    end
`else
    illegal = 1'b0;
`endif
  end

  assign dec_cword = {2'b00, (f3_v ? f3 : 3'b000), illegal, branch_v, jump_v, imm_pt_v,
                      rs1_pc_sel, alt_art, imm_v, dc_w_v, dc_r_v, pc_w_v, rd_w_v};

  always_comb begin
    dec_cword_ext       = '0;
    dec_cword_ext[15:0] = dec_cword;
  end

  logic [XLEN-1:0]    mem_pc    [BUF_DEPTH];
  logic [4:0]         mem_rs1   [BUF_DEPTH];
  logic [4:0]         mem_rs2   [BUF_DEPTH];
  logic [4:0]         mem_rd    [BUF_DEPTH];
  logic [XLEN-1:0]    mem_imm   [BUF_DEPTH];
  logic [CWORD_W-1:0] mem_cword [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CNT_W'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_rs1[i]   <= '0;
        mem_rs2[i]   <= '0;
        mem_rd[i]    <= '0;
        mem_imm[i]   <= '0;
        mem_cword[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= in_pc;
        mem_rs1[wr_ptr]   <= in_instr[19:15];
        mem_rs2[wr_ptr]   <= in_instr[24:20];
        mem_rd[wr_ptr]    <= in_instr[11:7];
        mem_imm[wr_ptr]   <= dec_imm;
        mem_cword[wr_ptr] <= dec_cword_ext;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign out_pc    = mem_pc[rd_ptr];
  assign out_rs1   = mem_rs1[rd_ptr];
  assign out_rs2   = mem_rs2[rd_ptr];
  assign out_rd    = mem_rd[rd_ptr];
  assign out_imm   = mem_imm[rd_ptr];
  assign out_cword = mem_cword[rd_ptr];

endmodule
